// File: rtl/clk_div_pkg.sv
// Shared constants and divisor clamp for the multi-channel tick divider.
// Combinational helpers only; no latency, no flow control.
// Divisor values are carried as 32-bit words and narrowed by the user.
package clk_div_pkg;

    localparam int DIV_MIN   = 1;
    localparam int MAX_CNT_W = 32;

    // A divisor of zero would never wrap, so it is promoted to the smallest legal value.
    function automatic logic [MAX_CNT_W-1:0] div_clamp(input logic [MAX_CNT_W-1:0] val);
        return (val == '0) ? MAX_CNT_W'(DIV_MIN) : val;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: shadow/active divisor, phase counter, tick strobe, square wave.
// Outputs registered, first tick on the d-th enabled edge, then every d cycles.
// No backpressure; a divisor write is always accepted into the shadow.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             core_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_vld,
    input  logic [CNT_W-1:0] wr_dat,
    output logic             tick,
    output logic             sq_clk
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] cnt;

    logic [CNT_W-1:0] eff_shadow;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] div_nx;
    logic [CNT_W-1:0] half_nx;
    logic             tick_nx;
    logic             sq_nx;

    always_comb begin
        eff_shadow = wr_vld ? wr_dat : shadow;
        cnt_nx     = cnt;
        div_nx     = div_act;
        tick_nx    = 1'b0;
        sq_nx      = 1'b0;
        half_nx    = '0;
        if (!en) begin
            cnt_nx = '0;
            div_nx = eff_shadow;
        end else if (sync) begin
            cnt_nx = '0;
            div_nx = eff_shadow;
            sq_nx  = 1'b1;
        end else begin
            if (cnt == div_act - CNT_W'(1)) begin
                cnt_nx  = '0;
                tick_nx = 1'b1;
                div_nx  = eff_shadow;
            end else begin
                cnt_nx = cnt + CNT_W'(1);
            end
            // ceil(d/2) without widening, so d = 2**CNT_W-1 stays in range
            half_nx = (div_nx >> 1) + CNT_W'(div_nx[0]);
            sq_nx   = (cnt_nx < half_nx);
        end
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            shadow  <= DIV_RST;
            div_act <= DIV_RST;
            cnt     <= '0;
            tick    <= 1'b0;
            sq_clk  <= 1'b0;
        end else begin
            shadow  <= eff_shadow;
            div_act <= div_nx;
            cnt     <= cnt_nx;
            tick    <= tick_nx;
            sq_clk  <= sq_nx;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// N_CH independent tick/square-wave dividers sharing one sync pulse and one divisor write port.
// Outputs registered; each channel ticks on its d-th enabled edge, then every d cycles.
// No backpressure; writes to a channel index beyond N_CH are dropped.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int N_CH        = 4,
    parameter  int CNT_W       = 16,
    parameter  int DEFAULT_DIV = 2,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [N_CH-1:0]  i_en,
    input  logic             i_sync,
    input  logic             i_div_we,
    input  logic [CH_W-1:0]  i_div_ch,
    input  logic [CNT_W-1:0] i_div_val,
    output logic [N_CH-1:0]  o_tick,
    output logic [N_CH-1:0]  o_clk
);

    logic [CNT_W-1:0] div_val_cl;

    assign div_val_cl = CNT_W'(div_clamp(MAX_CNT_W'(i_div_val)));

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic wr_vld;

        assign wr_vld = i_div_we && (i_div_ch == CH_W'(c));

        clk_div_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .core_clk (i_CLK),
            .rst      (i_RST),
            .en       (i_en[c]),
            .sync     (i_sync),
            .wr_vld   (wr_vld),
            .wr_dat   (div_val_cl),
            .tick     (o_tick[c]),
            .sq_clk   (o_clk[c])
        );
    end

endmodule
